a5_keystream_engine: RTL

//  Parametrised A5/1 keystream engine. Serially loads a 64-bit key and a 22-bit frame number,

---
 rtl/a5_keystream_engine_if.sv | 24 ++
 rtl/a5_keystream_engine.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/a5_keystream_engine_if.sv
// Keystream output stream: one OUT_W-bit word per valid/ready handshake,
// with out_last marking the word that carries the final burst bit.
interface a5_keystream_engine_if #(
  parameter int OUT_W = 8
);
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/a5_keystream_engine.sv
// A5/1 keystream engine: serial key/frame load, majority-clocked mix, then one
// burst of keystream bits packed MSB-first into words on a back-pressured stream.
module a5_keystream_engine #(
  parameter int OUT_W      = 8,
  parameter int MIX_CYCLES = 100,
  parameter int BURST_BITS = 228
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [63:0]          key,
  input  logic [21:0]          frame,
  a5_keystream_engine_if.master stream,
  output logic                 busy,
  output logic                 done
);

  localparam int LOAD_BITS = 86;
  localparam int CNT_MAX   = (MIX_CYCLES > LOAD_BITS) ? MIX_CYCLES : LOAD_BITS;
  localparam int CNT_W     = $clog2(CNT_MAX);
  localparam int BC_W      = (BURST_BITS > 1) ? $clog2(BURST_BITS) : 1;
  localparam int PC_W      = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, MIX, RUN, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [18:0]      r1_q, r1_d, r1_s, r1_m;
  logic [21:0]      r2_q, r2_d, r2_s, r2_m;
  logic [22:0]      r3_q, r3_d, r3_s, r3_m;
  logic [85:0]      sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [PC_W-1:0]  pk_cnt_q, pk_cnt_d;
  logic [OUT_W-1:0] pk_q, pk_d, packed_word;
  logic [OUT_W-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             in_bit, maj, step_all, ks_bit, accept, word_full;

  // Candidate next value of every register, then gated by LOAD or majority vote.
  always_comb begin
    in_bit   = (state_q == LOAD) ? sr_q[0] : 1'b0;
    step_all = (state_q == LOAD);
    maj      = (r1_q[8] & r2_q[10]) | (r1_q[8] & r3_q[10]) | (r2_q[10] & r3_q[10]);
    r1_s     = {r1_q[17:0], r1_q[18] ^ r1_q[17] ^ r1_q[16] ^ r1_q[13] ^ in_bit};
    r2_s     = {r2_q[20:0], r2_q[21] ^ r2_q[20] ^ in_bit};
    r3_s     = {r3_q[21:0], r3_q[22] ^ r3_q[21] ^ r3_q[20] ^ r3_q[7] ^ in_bit};
    r1_m     = (step_all || (r1_q[8]  == maj)) ? r1_s : r1_q;
    r2_m     = (step_all || (r2_q[10] == maj)) ? r2_s : r2_q;
    r3_m     = (step_all || (r3_q[10] == maj)) ? r3_s : r3_q;
    ks_bit   = r1_m[18] ^ r2_m[21] ^ r3_m[22];
  end

  always_comb begin
    state_d   = state_q;
    r1_d      = r1_q;
    r2_d      = r2_q;
    r3_d      = r3_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    pk_cnt_d  = pk_cnt_q;
    pk_d      = pk_q;
    data_d    = data_q;
    valid_d   = valid_q;
    last_d    = last_q;
    done_d    = 1'b0;
    accept    = valid_q & stream.out_ready;
    word_full = (pk_cnt_q == PC_W'(OUT_W - 1)) || (bit_cnt_q == '0);
    packed_word = pk_q;
    packed_word[PC_W'(OUT_W - 1) - pk_cnt_q] = ks_bit;

    if (accept) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end

    case (state_q)
      LOAD: begin
        r1_d = r1_m;
        r2_d = r2_m;
        r3_d = r3_m;
        sr_d = sr_q >> 1;
        if (cnt_q == '0) begin
          state_d = MIX;
          cnt_d   = CNT_W'(MIX_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      MIX: begin
        r1_d = r1_m;
        r2_d = r2_m;
        r3_d = r3_m;
        if (cnt_q == '0) state_d = RUN;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      RUN: begin
        // A completed word needs a free output register; otherwise everything holds.
        if (!word_full || !valid_q || accept) begin
          r1_d = r1_m;
          r2_d = r2_m;
          r3_d = r3_m;
          if (word_full) begin
            data_d   = packed_word;
            valid_d  = 1'b1;
            last_d   = (bit_cnt_q == '0);
            pk_d     = '0;
            pk_cnt_d = '0;
          end else begin
            pk_d     = packed_word;
            pk_cnt_d = pk_cnt_q + PC_W'(1);
          end
          if (bit_cnt_q == '0) state_d   = DRAIN;
          else                 bit_cnt_d = bit_cnt_q - BC_W'(1);
        end
      end
      DRAIN: begin
        if (accept && last_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: ;
    endcase

    if (start) begin
      state_d   = LOAD;
      r1_d      = '0;
      r2_d      = '0;
      r3_d      = '0;
      sr_d      = {frame, key};
      cnt_d     = CNT_W'(LOAD_BITS - 1);
      bit_cnt_d = BC_W'(BURST_BITS - 1);
      pk_d      = '0;
      pk_cnt_d  = '0;
      data_d    = '0;
      valid_d   = 1'b0;
      last_d    = 1'b0;
      done_d    = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      r1_q      <= '0;
      r2_q      <= '0;
      r3_q      <= '0;
      sr_q      <= '0;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      pk_cnt_q  <= '0;
      pk_q      <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      r1_q      <= r1_d;
      r2_q      <= r2_d;
      r3_q      <= r3_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      pk_cnt_q  <= pk_cnt_d;
      pk_q      <= pk_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign stream.out_data  = data_q;
  assign stream.out_valid = valid_q;
  assign stream.out_last  = valid_q & last_q;
  assign busy             = busy_q;
  assign done             = done_q;

endmodule
